overture_prog_loader: RTL and testbench
=======================================

OVERTURE_PROG_LOADER -- requirements
Module: overture_prog_loader

Interface
REQ-001 The module SHALL have one parameter: ADDR_W, default 8, program-memory address width (depth 2**ADDR_W bytes).
REQ-002 The module SHALL have port clk, input, 1 bit: single clock, all state rising-edge.
REQ-003 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port load_start, input, 1 bit: single-cycle request to begin a load.
REQ-005 The module SHALL have port load_len, input, ADDR_W bits: byte count, sampled with load_start; 0 means 2**ADDR_W.
REQ-006 The module SHALL have port in_valid, input, 1 bit: in_data holds a program byte.
REQ-007 The module SHALL have port in_data, input, 8 bits: program byte.
REQ-008 The module SHALL have port in_ready, output, 1 bit: loader accepts a byte this cycle.
REQ-009 The module SHALL have port pc, input, ADDR_W bits: CPU fetch address.
REQ-010 The module SHALL have port instr, output, 8 bits: program byte at pc, fed to the CPU.
REQ-011 The module SHALL have port cpu_reset, output, 1 bit: active-high reset driven to the downstream overture_cpu.
REQ-012 The module SHALL have port cpu_run, output, 1 bit: run enable driven to overture_cpu.
REQ-013 The module SHALL have port load_count, output, ADDR_W+1 bits: bytes written in the current or last load.
REQ-014 The module SHALL have port done, output, 1 bit: last load completed.

Function
REQ-015 The module SHALL implement the states IDLE, LOAD, RELEASE and RUN.
REQ-016 IDLE: cpu_reset=1, cpu_run=0, in_ready=0; load_start moves to LOAD, clears load_count and done, and latches the target length (ADDR_W+1 bits).
REQ-017 LOAD: in_ready=1, cpu_reset=1, cpu_run=0; a byte transfers on the cycle where in_valid and in_ready are both 1.
REQ-018 Each transfer SHALL write in_data to memory[load_count[ADDR_W-1:0]] and increment load_count.
REQ-019 The transfer that makes load_count equal the target SHALL be the last accepted; the next state is RELEASE and in_ready SHALL be 0 from the following cycle.
REQ-020 RELEASE SHALL last exactly one cycle with cpu_reset=1 and cpu_run=0, then move to RUN with done=1.
REQ-021 RUN: cpu_reset=0, cpu_run=1, in_ready=0; the first cycle of CPU execution is the second cycle after the last byte transfer.
REQ-022 load_start in RUN or LOAD SHALL abort the current activity and behave as in REQ-016, entering LOAD on the next cycle with cpu_reset=1 and cpu_run=0.
REQ-023 Memory bytes beyond the loaded length SHALL retain prior contents; no clearing is performed.
REQ-024 instr SHALL be a combinational read of memory[pc] in every state; a write and a read of the same address in one cycle returns the old byte.
REQ-025 in_valid while in_ready=0 SHALL be ignored without side effects.
REQ-026 load_len=0 SHALL load exactly 2**ADDR_W bytes; load_count reaches 2**ADDR_W without wrap.

Reset
REQ-027 On reset low, the module SHALL enter IDLE with load_count=0, done=0, in_ready=0, cpu_reset=1 and cpu_run=0, independent of clk.
REQ-028 Reset SHALL NOT clear memory contents; reset during LOAD discards progress and leaves partially written bytes in place.

Structure
REQ-029 The state enum and the RELEASE length constant (1) SHALL live in a shared package, overture_pkg.
REQ-030 The memory SHALL be a sub-module, overture_prog_mem, with one synchronous write port and one asynchronous read port.
REQ-031 The implementation SHALL NOT instantiate overture_cpu; integration is done in the pgm_ wrapper.

Verification
REQ-032 The bench SHALL check this scenario: reset low then high -> cpu_reset=1, cpu_run=0, done=0, in_ready=0, load_count=0.
REQ-033 The bench SHALL check this scenario: load_start with load_len=4, bytes 0x11,0x22,0x33,0x44 on consecutive cycles -> in_ready drops after the 4th, cpu_run=1 two cycles after it, done=1, and pc=2 gives instr=0x33.
REQ-034 The bench SHALL check this scenario: load_len=3 with in_valid toggled 1,0,1,0,1 -> exactly 3 writes, load_count=3, and the bubbles cause no writes.
REQ-035 The bench SHALL check this scenario: load_start in RUN with load_len=1, byte 0xAA -> cpu_reset asserts the next cycle, memory[0]=0xAA, and memory[1..] is unchanged.
REQ-036 The bench SHALL check this scenario: load_len=0 with 256 bytes of value i -> load_count=256, pc=255 gives instr=0xFF, then RUN.
REQ-037 The bench SHALL check this scenario: reset asserted after 2 of 4 bytes -> IDLE immediately, memory[0..1] holds the new bytes, load_count=0.

Source files
------------

// File: rtl/overture_pkg.sv
// Shared definitions for the overture program loader.
// Holds the loader state encoding and the length of the RELEASE
// window between the last byte written and the CPU being let go.
package overture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } loader_state_e;

    // Number of cycles the CPU is still held in reset after the last byte.
    localparam int unsigned RELEASE_CYCLES = 1;

    // Width of the RELEASE window counter and its terminal value.
    localparam int unsigned REL_CNT_W = 4;
    localparam logic [REL_CNT_W-1:0] REL_LAST = 4'(RELEASE_CYCLES - 1);

endpackage

// File: rtl/overture_prog_mem.sv
// Program memory for the overture loader.
// One synchronous write port and one asynchronous (combinational) read
// port. Contents are never cleared, not even by reset. A write and a read
// of the same address in one cycle returns the old byte, since the write
// only lands on the clock edge.
// Ports:
//   clk      - write clock
//   wr_en    - write strobe
//   wr_addr  - write address
//   wr_data  - byte to write
//   rd_addr  - read address
//   rd_data  - byte at rd_addr (combinational)
module overture_prog_mem #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    logic [7:0] mem_r [0:(2**ADDR_W)-1];

    // Synchronous write port; no reset so program bytes survive resets.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/overture_prog_loader.sv
// Program loader for the overture CPU.
// Streams load_len bytes (0 means the full 2**ADDR_W) into program memory
// while holding the CPU in reset, waits one RELEASE cycle, then lets the
// CPU run from the loaded image. load_start in any state restarts a load.
// Ports:
//   clk, reset   - clock and asynchronous active-low reset
//   load_start   - one-cycle request to start a load, samples load_len
//   load_len     - byte count of the load (0 = 2**ADDR_W)
//   in_valid     - in_data carries a program byte
//   in_data      - program byte
//   in_ready     - a byte is accepted this cycle when in_valid is high
//   pc           - CPU fetch address
//   instr        - program byte at pc (combinational)
//   cpu_reset    - active-high reset for the CPU
//   cpu_run      - CPU run enable
//   load_count   - bytes written by the current or last load
//   done         - last load completed and CPU released
module overture_prog_loader
    import overture_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_len,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] pc,
    output logic [7:0]        instr,
    output logic              cpu_reset,
    output logic              cpu_run,
    output logic [ADDR_W:0]   load_count,
    output logic              done
);

    loader_state_e        state_r;
    logic [ADDR_W:0]      count_r;
    logic [ADDR_W:0]      target_r;
    logic                 done_r;
    logic                 in_ready_r;
    logic                 cpu_reset_r;
    logic                 cpu_run_r;
    logic [REL_CNT_W-1:0] rel_cnt_r;

    logic                 wr_en_s;
    logic [ADDR_W:0]      count_inc_s;
    logic                 last_s;
    logic [ADDR_W:0]      target_s;

    // Transfer qualification and target length decode.
    // in_ready_r is high exactly while loading, so it doubles as the
    // "in LOAD" qualifier. A restart request suppresses the write so the
    // aborted load leaves no byte behind in that cycle.
    always_comb begin
        wr_en_s     = in_ready_r & in_valid & ~load_start;
        count_inc_s = count_r + {{ADDR_W{1'b0}}, 1'b1};
        last_s      = wr_en_s && (count_inc_s == target_r);
        if (load_len == {ADDR_W{1'b0}}) begin
            target_s = {1'b1, {ADDR_W{1'b0}}};
        end else begin
            target_s = {1'b0, load_len};
        end
    end

    // Loader FSM with registered handshake and CPU control outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            count_r     <= {(ADDR_W+1){1'b0}};
            target_r    <= {(ADDR_W+1){1'b0}};
            done_r      <= 1'b0;
            in_ready_r  <= 1'b0;
            cpu_reset_r <= 1'b1;
            cpu_run_r   <= 1'b0;
            rel_cnt_r   <= {REL_CNT_W{1'b0}};
        end else if (load_start) begin
            state_r     <= ST_LOAD;
            count_r     <= {(ADDR_W+1){1'b0}};
            target_r    <= target_s;
            done_r      <= 1'b0;
            in_ready_r  <= 1'b1;
            cpu_reset_r <= 1'b1;
            cpu_run_r   <= 1'b0;
            rel_cnt_r   <= {REL_CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r <= ST_IDLE;
                end
                ST_LOAD: begin
                    if (wr_en_s) begin
                        count_r <= count_inc_s;
                        if (last_s) begin
                            state_r    <= ST_RELEASE;
                            in_ready_r <= 1'b0;
                            rel_cnt_r  <= {REL_CNT_W{1'b0}};
                        end
                    end
                end
                ST_RELEASE: begin
                    if (rel_cnt_r == REL_LAST) begin
                        state_r     <= ST_RUN;
                        done_r      <= 1'b1;
                        cpu_reset_r <= 1'b0;
                        cpu_run_r   <= 1'b1;
                    end else begin
                        rel_cnt_r <= rel_cnt_r + {{(REL_CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_RUN: begin
                    state_r <= ST_RUN;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    in_ready_r  <= 1'b0;
                    cpu_reset_r <= 1'b1;
                    cpu_run_r   <= 1'b0;
                end
            endcase
        end
    end

    overture_prog_mem #(
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en_s),
        .wr_addr (count_r[ADDR_W-1:0]),
        .wr_data (in_data),
        .rd_addr (pc),
        .rd_data (instr)
    );

    assign in_ready   = in_ready_r;
    assign cpu_reset  = cpu_reset_r;
    assign cpu_run    = cpu_run_r;
    assign load_count = count_r;
    assign done       = done_r;

endmodule

// File: tb/tb_overture_prog_loader.sv
// Self-checking bench for overture_prog_loader.
// A behavioural model (phase + byte array + known mask) is advanced on
// every rising edge and every DUT output is compared against it on the
// following falling edge. Directed scenarios add literal expectations,
// then randomized loads with bubbles, aborts and random fetch addresses.
module tb_overture_prog_loader;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;

    localparam int PH_IDLE = 0;
    localparam int PH_LOAD = 1;
    localparam int PH_REL  = 2;
    localparam int PH_RUN  = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              load_start = 1'b0;
    logic [ADDR_W-1:0] load_len = 8'd0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'd0;
    logic              in_ready;
    logic [ADDR_W-1:0] pc = 8'd0;
    logic [7:0]        instr;
    logic              cpu_reset;
    logic              cpu_run;
    logic [ADDR_W:0]   load_count;
    logic              done;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] m_mem   [DEPTH];
    bit         m_known [DEPTH];
    int         m_phase;
    int         m_count;
    int         m_target;
    bit         m_done;

    always #5 clk = ~clk;

    overture_prog_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .load_len   (load_len),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .pc         (pc),
        .instr      (instr),
        .cpu_reset  (cpu_reset),
        .cpu_run    (cpu_run),
        .load_count (load_count),
        .done       (done)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = PH_IDLE;
        m_count = 0;
        m_done  = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs in force.
    task automatic model_step();
        if (load_start) begin
            m_phase  = PH_LOAD;
            m_count  = 0;
            m_done   = 1'b0;
            m_target = (load_len == 8'd0) ? DEPTH : int'(load_len);
        end else if (m_phase == PH_LOAD) begin
            if (in_valid) begin
                m_mem[m_count % DEPTH]   = in_data;
                m_known[m_count % DEPTH] = 1'b1;
                m_count++;
                if (m_count == m_target) m_phase = PH_REL;
            end
        end else if (m_phase == PH_REL) begin
            m_phase = PH_RUN;
            m_done  = 1'b1;
        end
    endtask

    task automatic compare_all();
        check("in_ready",   int'(in_ready),   int'(m_phase == PH_LOAD));
        check("cpu_reset",  int'(cpu_reset),  int'(m_phase != PH_RUN));
        check("cpu_run",    int'(cpu_run),    int'(m_phase == PH_RUN));
        check("load_count", int'(load_count), m_count);
        check("done",       int'(done),       int'(m_done));
        if (m_known[pc]) check("instr", int'(instr), int'(m_mem[pc]));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic start_load(input int len);
        load_start = 1'b1;
        load_len   = 8'(len);
        cycle();
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic peek(input string name, input logic [7:0] addr, input int exp);
        pc = addr;
        #1;
        check(name, int'(instr), exp);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            m_known[i] = 1'b0;
            m_mem[i]   = 8'd0;
        end
        model_reset();

        // Reset low then high
        repeat (2) @(negedge clk);
        reset = 1'b1;
        cycle();
        check("rst_cpu_reset",  int'(cpu_reset),  1);
        check("rst_cpu_run",    int'(cpu_run),    0);
        check("rst_done",       int'(done),       0);
        check("rst_in_ready",   int'(in_ready),   0);
        check("rst_load_count", int'(load_count), 0);

        // Four back-to-back bytes
        start_load(4);
        check("s4_in_ready", int'(in_ready), 1);
        begin
            logic [7:0] seq [4];
            seq = '{8'h11, 8'h22, 8'h33, 8'h44};
            for (int i = 0; i < 4; i++) begin
                in_valid = 1'b1;
                in_data  = seq[i];
                cycle();
            end
        end
        in_valid = 1'b0;
        check("s4_ready_drop", int'(in_ready), 0);
        check("s4_run_early",  int'(cpu_run),  0);
        pc = 8'd2;
        cycle();
        check("s4_cpu_run",  int'(cpu_run),   1);
        check("s4_done",     int'(done),      1);
        check("s4_instr_pc2", int'(instr),    8'h33);

        // Bubbles on in_valid: 1,0,1,0,1
        start_load(3);
        begin
            logic [7:0] bs [5];
            bs = '{8'h5A, 8'hE1, 8'h6B, 8'hE2, 8'h7C};
            for (int i = 0; i < 5; i++) begin
                in_valid = (i % 2 == 0);
                in_data  = bs[i];
                cycle();
            end
        end
        in_valid = 1'b0;
        check("s3_load_count", int'(load_count), 3);
        cycle();
        cycle();
        check("s3_running", int'(cpu_run), 1);
        // in_valid while not ready must be ignored
        in_valid = 1'b1;
        in_data  = 8'hEE;
        cycle();
        cycle();
        in_valid = 1'b0;
        check("s3_ignored_count", int'(load_count), 3);
        peek("s3_mem0", 8'd0, 8'h5A);
        peek("s3_mem1", 8'd1, 8'h6B);
        peek("s3_mem2", 8'd2, 8'h7C);
        peek("s3_mem3", 8'd3, 8'h44);

        // Restart from RUN with a one-byte load
        start_load(1);
        check("s1_cpu_reset", int'(cpu_reset), 1);
        check("s1_cpu_run",   int'(cpu_run),   0);
        send_byte(8'hAA);
        cycle();
        cycle();
        peek("s1_mem0", 8'd0, 8'hAA);
        peek("s1_mem1", 8'd1, 8'h6B);
        peek("s1_mem2", 8'd2, 8'h7C);

        // Full-depth load via load_len = 0
        start_load(0);
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            cycle();
        end
        in_valid = 1'b0;
        check("sfull_count", int'(load_count), 256);
        peek("sfull_mem255", 8'd255, 8'hFF);
        cycle();
        cycle();
        check("sfull_run", int'(cpu_run), 1);

        // Reset after 2 of 4 bytes
        start_load(4);
        send_byte(8'hC1);
        send_byte(8'hC2);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        compare_all();
        check("sr_load_count", int'(load_count), 0);
        check("sr_cpu_reset",  int'(cpu_reset),  1);
        check("sr_in_ready",   int'(in_ready),   0);
        peek("sr_mem0", 8'd0, 8'hC1);
        peek("sr_mem1", 8'd1, 8'hC2);
        peek("sr_mem2", 8'd2, 8'h02);
        @(negedge clk);
        reset = 1'b1;
        cycle();

        // Randomized loads with bubbles, aborts and random fetches
        for (int it = 0; it < 30; it++) begin
            int budget;
            start_load($urandom_range(1, 24));
            budget = 0;
            while (m_phase != PH_RUN && budget < 400) begin
                if (m_phase == PH_LOAD && $urandom_range(0, 39) == 0) begin
                    in_valid = 1'b0;
                    start_load($urandom_range(1, 24));
                end else begin
                    in_valid = ($urandom_range(0, 2) != 0);
                    in_data  = 8'($urandom_range(0, 255));
                    pc       = 8'($urandom_range(0, 31));
                    cycle();
                end
                budget++;
            end
            in_valid = 1'b0;
            if (budget >= 400) check("rand_timeout", 0, 1);
            for (int k = 0; k < 4; k++) begin
                in_valid = ($urandom_range(0, 1) != 0);
                in_data  = 8'($urandom_range(0, 255));
                pc       = 8'($urandom_range(0, 255));
                cycle();
            end
            in_valid = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
